// File: rtl/mux_scan_seq_if.sv
// Sample output stream of the channel scan sequencer: (channel, data) pairs
// moved under a valid/ready handshake.
interface mux_scan_seq_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned SW = 4
);
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_ch;
   logic [DW-1:0] out_data;

   modport master (output out_valid, output out_ch, output out_data, input out_ready);
   modport slave  (input out_valid, input out_ch, input out_data, output out_ready);
endinterface

// File: rtl/mux_scan_seq.sv
// Walks the enabled channels of a 16:1 selector in ascending order, driving the
// select and streaming each sampled (channel, data) pair downstream.
module mux_scan_seq #(
   parameter int unsigned DW  = 4,
   parameter int unsigned NCH = 16,
   parameter int unsigned SW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NCH-1:0]   chan_en,
   input  logic [DW-1:0]    y,
   output logic [SW-1:0]    s,
   output logic             busy,
   output logic             done,
   mux_scan_seq_if.master   out_if
);

   localparam int unsigned MW = NCH + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEL  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [NCH-1:0] mask_q, mask_d;
   logic [SW-1:0]  s_q, s_d;
   logic           valid_q, valid_d;
   logic [SW-1:0]  ch_q, ch_d;
   logic [DW-1:0]  data_q, data_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [MW-1:0]  above_w;
   logic [MW-1:0]  cand_w;
   logic [SW:0]    first_w;
   logic [SW:0]    next_w;

   // Priority encoder: {found, lowest set index}; bit NCH is never set.
   function automatic logic [SW:0] lowest_set(input logic [MW-1:0] v);
      logic [SW:0] r;
      r = '0;
      for (int i = int'(MW) - 1; i >= 0; i--) begin
         if (v[i]) r = {1'b1, SW'(i)};
      end
      return r;
   endfunction

   // 17-bit arithmetic so that out_ch = 15 leaves no candidates (no wrap).
   assign above_w = ~((MW'(2) << ch_q) - MW'(1));
   assign cand_w  = {1'b0, mask_q} & above_w;
   assign first_w = lowest_set({1'b0, chan_en});
   assign next_w  = lowest_set(cand_w);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      s_d     = s_q;
      valid_d = valid_q;
      ch_d    = ch_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d = chan_en;
               if (first_w[SW]) begin
                  s_d     = first_w[SW-1:0];
                  state_d = ST_SEL;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_SEL: begin
            data_d  = y;
            ch_d    = s_q;
            valid_d = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (valid_q && out_if.out_ready) begin
               valid_d = 1'b0;
               if (next_w[SW]) begin
                  s_d     = next_w[SW-1:0];
                  state_d = ST_SEL;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         s_q     <= '0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign s                = s_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_ch    = ch_q;
   assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq with a behavioural 16:1 selector on y.
module tb_mux_scan_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] chan_en;
   logic [3:0]  y;
   logic [3:0]  s;
   logic        busy;
   logic        done;
   logic        rdy;
   logic        y_glitch;

   typedef struct packed {
      logic [3:0] ch;
      logic [3:0] data;
   } smp_t;

   smp_t exp_q[$];
   int   hs_cyc[$];
   int   done_cyc[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   mux_scan_seq_if #(.DW(4), .SW(4)) out_if ();

   mux_scan_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .chan_en (chan_en),
      .y       (y),
      .s       (s),
      .busy    (busy),
      .done    (done),
      .out_if  (out_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] dval(input logic [3:0] i);
      case (i)
         4'd0: return 4'd13;  4'd1: return 4'd4;   4'd2: return 4'd2;   4'd3: return 4'd7;
         4'd4: return 4'd1;   4'd5: return 4'd10;  4'd6: return 4'd6;   4'd7: return 4'd9;
         4'd8: return 4'd3;   4'd9: return 4'd14;  4'd10: return 4'd11; 4'd11: return 4'd0;
         4'd12: return 4'd5;  4'd13: return 4'd12; 4'd14: return 4'd15; default: return 4'd8;
      endcase
   endfunction

   // Selector model; y_glitch scrambles y to show it is ignored outside SEL.
   assign y = dval(s) ^ {4{y_glitch}};
   assign out_if.out_ready = rdy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void push(input logic [3:0] c, input logic [3:0] d);
      exp_q.push_back('{ch: c, data: d});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int d0, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (done_cyc.size() > d0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_within_bound", 32'(ok), 32'd1);
   endtask

   // Monitor: every accepted sample is popped and compared against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_if.out_valid && out_if.out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_sample", 32'(out_if.out_ch), 32'hFFFF);
            end else begin
               smp_t e;
               e = exp_q.pop_front();
               chk("sb_ch", 32'(out_if.out_ch), 32'(e.ch));
               chk("sb_data", 32'(out_if.out_data), 32'(e.data));
            end
         end
         if (done) done_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n0, d0, st;
      bit ok;
      rst = 1'b1; start = 1'b0; chan_en = '0; rdy = 1'b0; y_glitch = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_s", 32'(s), 0);
      chk("rst_valid", 32'(out_if.out_valid), 0);
      chk("rst_ch", 32'(out_if.out_ch), 0);
      chk("rst_data", 32'(out_if.out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b0;
      tick();

      // Sparse mask, full-rate sink
      rdy = 1'b1;
      push(0, 13); push(1, 4); push(2, 2); push(3, 7); push(5, 10); push(15, 8);
      n0 = hs_cyc.size(); d0 = done_cyc.size();
      start = 1'b1; chan_en = 16'h802F; st = cyc;
      tick();
      start = 1'b0;
      chk("t1_busy_during", 32'(busy), 1);
      wait_done(d0, 60, ok);
      chk("t1_count", 32'(hs_cyc.size() - n0), 6);
      if (hs_cyc.size() - n0 == 6) begin
         chk("t1_first_latency", 32'(hs_cyc[n0] - st), 2);
         for (int i = 1; i < 6; i++)
            chk("t1_spacing", 32'(hs_cyc[n0+i] - hs_cyc[n0+i-1]), 2);
         if (ok) chk("t1_done_after_last", 32'(done_cyc[d0]), 32'(hs_cyc[n0+5] + 1));
      end
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_done_low", 32'(done), 0);
      tick(); tick();
      chk("t1_done_once", 32'(done_cyc.size() - d0), 1);
      chk("t1_sb_empty", 32'(exp_q.size()), 0);

      // Empty mask: straight to FIN; a start during FIN is ignored
      n0 = hs_cyc.size(); d0 = done_cyc.size();
      start = 1'b1; chan_en = 16'h0000; st = cyc;
      tick();
      chk("t2_done_now", 32'(done), 1);
      chk("t2_busy_fin", 32'(busy), 1);
      chan_en = 16'h0001;
      tick();
      start = 1'b0;
      chk("t2_busy_after", 32'(busy), 0);
      repeat (4) tick();
      chk("t2_done_count", 32'(done_cyc.size() - d0), 1);
      if (done_cyc.size() > d0) chk("t2_latency", 32'(done_cyc[d0] - st), 1);
      chk("t2_no_samples", 32'(hs_cyc.size() - n0), 0);
      chk("t2_busy_idle", 32'(busy), 0);

      // Backpressure on a single channel; y disturbed while held
      rdy = 1'b0;
      push(2, 2);
      n0 = hs_cyc.size(); d0 = done_cyc.size();
      start = 1'b1; chan_en = 16'h0004;
      tick();
      start = 1'b0;
      tick();
      y_glitch = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(out_if.out_valid), 1);
         chk("t3_hold_ch", 32'(out_if.out_ch), 2);
         chk("t3_hold_data", 32'(out_if.out_data), 2);
         chk("t3_hold_s", 32'(s), 2);
         tick();
      end
      rdy = 1'b1;
      wait_done(d0, 10, ok);
      y_glitch = 1'b0;
      chk("t3_count", 32'(hs_cyc.size() - n0), 1);
      if (ok && hs_cyc.size() > n0) chk("t3_done_after_hs", 32'(done_cyc[d0]), 32'(hs_cyc[n0] + 1));
      chk("t3_sb_empty", 32'(exp_q.size()), 0);

      // Start and chan_en changes while busy are ignored
      push(0, 13); push(5, 10);
      n0 = hs_cyc.size(); d0 = done_cyc.size();
      start = 1'b1; chan_en = 16'h0021;
      tick();
      start = 1'b1; chan_en = 16'hFFFF;
      tick();
      start = 1'b0;
      wait_done(d0, 40, ok);
      chk("t4_orig_mask_count", 32'(hs_cyc.size() - n0), 2);
      chk("t4_sb_empty", 32'(exp_q.size()), 0);

      // New mask on the next start: all 16 channels in order
      for (int i = 0; i < 16; i++) push(4'(i), dval(4'(i)));
      n0 = hs_cyc.size(); d0 = done_cyc.size();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(d0, 80, ok);
      chk("t4_full_count", 32'(hs_cyc.size() - n0), 16);
      chk("t4_full_sb_empty", 32'(exp_q.size()), 0);

      // Asynchronous reset while the second sample is presented
      rdy = 1'b1;
      push(0, 13);
      d0 = done_cyc.size();
      start = 1'b1; chan_en = 16'h802F;
      tick();
      start = 1'b0;
      tick();
      tick();
      rdy = 1'b0;
      tick();
      chk("t5_second_valid", 32'(out_if.out_valid), 1);
      chk("t5_second_ch", 32'(out_if.out_ch), 1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_if.out_valid), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_s", 32'(s), 0);
      chk("t5_rst_data", 32'(out_if.out_data), 0);
      tick();
      rst = 1'b0;
      rdy = 1'b1;
      repeat (3) tick();
      chk("t5_no_done", 32'(done_cyc.size() - d0), 0);
      chk("t5_busy_idle", 32'(busy), 0);
      chk("t5_sb_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Sequencer that sits directly upstream of the 16:1 x 4-bit selector (mux_n).
- Drives the 4-bit select, walks the enabled channels in ascending index order, and samples the selector output one channel at a time.
- Delivers each (channel, data) pair on a valid/ready output stream.
- Lets downstream logic read a programmable subset of the 16 data inputs without handling the select itself.

Parameters:
- DW, 4, data width of the selector output and of out_data.
- NCH, 16, number of channels; fixed at 16 for this revision.
- SW, 4, select / channel-index width, equal to log2(NCH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan pass; sampled only in IDLE.
- chan_en  input  16  channel enable mask; bit i enables channel i; latched on accepted start.
- y  input  DW  selector output (mux_n y), combinational function of s.
- s  output  SW  selector select, registered.
- out_valid  output  1  out_ch/out_data hold a valid sample.
- out_ready  input  1  downstream accepts the sample.
- out_ch  output  SW  channel index of the current sample.
- out_data  output  DW  sampled selector data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, s=0, out_valid=0, out_ch=0, out_data=0, busy=0, done=0, internal mask=0.
- FSM states: IDLE, SEL, OUT, FIN.
- IDLE, start=1:
  - Latch chan_en into mask.
  - If mask==0, go to FIN.
  - Otherwise s <= lowest set index in mask, go to SEL.
- IDLE, start=0: stay in IDLE; s holds its last value.
- SEL: the select settles during this cycle. At the clock edge:
  - out_data <= y, out_ch <= s, out_valid <= 1.
  - Go to OUT.
- OUT, holding: while out_valid && !out_ready, out_ch, out_data and s stay stable.
- OUT, handshake (out_valid && out_ready):
  - out_valid <= 0.
  - Search mask for the lowest set index strictly greater than out_ch.
  - If one is found, s <= that index and go to SEL.
  - If none is found, go to FIN.
  - No wrap-around: index 15 is always the last channel of a pass.
- FIN: done=1 for exactly this one cycle, busy=1; go to IDLE.
- busy = (state != IDLE).
- Latency:
  - start edge to first out_valid = 2 cycles (IDLE->SEL, SEL->OUT).
  - Handshake to next out_valid = 2 cycles.
  - Maximum throughput is 1 sample per 2 cycles.
- Inputs that are ignored:
  - start while busy, including the FIN cycle.
  - chan_en changes after latch; they take effect on the next start only.
- y is sampled only in SEL; y changes in other states have no effect.
- Width rules: the next-index search is a priority encoder over mask & ~((2 << out_ch) - 1), computed at 17 bits so out_ch=15 yields an empty set.
- Reset during OUT with out_valid=1: out_valid drops at once; the sample is lost and no done pulse is generated.

Test Plan:
- Apply reset, hold rst=1 for 3 cycles -> all outputs 0 and state IDLE; assert rst mid-pass at the second sample -> out_valid, busy and s return to 0 asynchronously.
- Bench drives a mux_n model with d0=13, d1=4, d2=2, d3=7, d5=10, d15=8. Pulse start with chan_en=16'h802F, out_ready=1 ->
  - (ch,data) sequence (0,13) (1,4) (2,2) (3,7) (5,10) (15,8).
  - Samples spaced 2 cycles apart; done pulses once after (15,8); busy falls the next cycle.
- Pulse start with chan_en=16'h0000 -> no out_valid, done=1 exactly one cycle, start->done latency 1 cycle.
- Pulse start with chan_en=16'h0004, out_ready=0 for 5 cycles -> out_valid held, out_ch=2, out_data=2, s=2 stable throughout; the handshake on cycle 6 is followed by done.
- While busy, pulse start and change chan_en to 16'hFFFF -> the pass continues with the original mask. After done, start again -> the new mask is applied and 16 samples come out in order 0..15.
